// File: rtl/external_io_fifo.sv
// ---------------------------------------------------------------------------
// external_io_fifo
//   Host-facing SPI I/O block for the hashing pool.
//   SPI0 loads the job config. SPI1 loads the device config, and in DONE it
//   reads back a framed result stream. The frame is a COUNT_WIDTH header
//   holding the occupancy, then the buffered entries MSB-first, then sdi1
//   pass-through. Up to RESULT_DEPTH shapool hits are buffered, so the core
//   keeps running after the first hit.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   host_hold         1 = host holds the block in LOAD (config shifting)
//   sck0/sdi0/cs0_n   SPI0 (job config); sck/sdi are asynchronous
//   sck1/sdi1/cs1_n   SPI1 (device config in LOAD, result readout in DONE)
//   sdo1              SPI1 data out
//   device_config     loaded device config
//   job_config        loaded job config
//   job_valid         JOB_CONFIG_WIDTH bits shifted since entering LOAD
//   core_reset_n      run (1) / hold (0) for the hash core
//   shapool_success   one-cycle pulse qualifying shapool_result
//   shapool_result    result entry captured on shapool_success
//   ready             1 while in DONE
//   result_count      current FIFO occupancy
// ---------------------------------------------------------------------------
module external_io_fifo #(
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int JOB_CONFIG_WIDTH    = 352,
  parameter int RESULT_DATA_WIDTH   = 40,
  parameter int RESULT_DEPTH        = 4,
  parameter int COUNT_WIDTH         = 8,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           host_hold,
  input  logic                           sck0,
  input  logic                           sdi0,
  input  logic                           cs0_n,
  input  logic                           sck1,
  input  logic                           sdi1,
  output logic                           sdo1,
  input  logic                           cs1_n,
  output logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
  output logic [JOB_CONFIG_WIDTH-1:0]    job_config,
  output logic                           job_valid,
  output logic                           core_reset_n,
  input  logic                           shapool_success,
  input  logic [RESULT_DATA_WIDTH-1:0]   shapool_result,
  output logic                           ready,
  output logic [COUNT_WIDTH-1:0]         result_count
);

  localparam int JBW     = $clog2(JOB_CONFIG_WIDTH + 1);
  localparam int PTR_W   = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int RO_W    = COUNT_WIDTH + RESULT_DATA_WIDTH;
  localparam int FLD_MAX = (COUNT_WIDTH > RESULT_DATA_WIDTH) ? COUNT_WIDTH : RESULT_DATA_WIDTH;
  localparam int FC_W    = $clog2(FLD_MAX + 1);

  typedef enum logic [1:0] {S_LOAD, S_EXEC, S_DONE} state_t;
  // Which field of the readout frame is currently at the shift position.
  typedef enum logic [1:0] {F_HDR, F_ENTRY, F_PASS} phase_t;

  state_t r_state, w_state_nxt;
  phase_t r_phase;

  logic [SYNC_STAGES-1:0]         r_sck0_sync, r_sdi0_sync, r_sck1_sync, r_sdi1_sync;
  logic [JOB_CONFIG_WIDTH-1:0]    r_job_config;
  logic [DEVICE_CONFIG_WIDTH-1:0] r_device_config;
  logic [JBW-1:0]                 r_job_bits;
  logic                           r_core_reset_n;
  logic [RESULT_DATA_WIDTH-1:0]   r_mem [RESULT_DEPTH];
  logic [PTR_W-1:0]               r_rd_ptr, r_wr_ptr;
  logic [COUNT_WIDTH-1:0]         r_count;
  logic [RO_W-1:0]                r_readout;
  logic [FC_W-1:0]                r_frame_cnt;

  logic                         w_sck0_rise, w_sck1_rise, w_sdi0, w_sdi1;
  logic                         w_job_valid, w_not_full, w_last_slot;
  logic                         w_shift_job, w_shift_dev, w_push, w_clear;
  logic                         w_ro_shift, w_ro_reload, w_pop;
  logic [COUNT_WIDTH-1:0]       w_count_nxt;
  logic [RESULT_DATA_WIDTH-1:0] w_head;
  logic [RO_W-1:0]              w_ro_shifted;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Synchronisers carry no reset: they only track the pins, and a reset
  // value could fabricate an edge if sck is high when reset releases.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    r_sck0_sync <= {r_sck0_sync[SYNC_STAGES-2:0], sck0};
    r_sdi0_sync <= {r_sdi0_sync[SYNC_STAGES-2:0], sdi0};
    r_sck1_sync <= {r_sck1_sync[SYNC_STAGES-2:0], sck1};
    r_sdi1_sync <= {r_sdi1_sync[SYNC_STAGES-2:0], sdi1};
  end

  // Rising edge: last stage still 0 while the stage before it is already 1.
  assign w_sck0_rise = r_sck0_sync[SYNC_STAGES-2] & ~r_sck0_sync[SYNC_STAGES-1];
  assign w_sck1_rise = r_sck1_sync[SYNC_STAGES-2] & ~r_sck1_sync[SYNC_STAGES-1];
  assign w_sdi0      = r_sdi0_sync[SYNC_STAGES-1];
  assign w_sdi1      = r_sdi1_sync[SYNC_STAGES-1];

  assign w_job_valid = (r_job_bits == JBW'(JOB_CONFIG_WIDTH));
  assign w_not_full  = (r_count != COUNT_WIDTH'(RESULT_DEPTH));
  assign w_last_slot = (r_count == COUNT_WIDTH'(RESULT_DEPTH - 1));

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_job = 1'b0;
    w_shift_dev = 1'b0;
    w_push      = 1'b0;
    w_clear     = 1'b0;
    w_ro_shift  = 1'b0;
    w_ro_reload = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (host_hold) begin
          w_shift_job = ~cs0_n & w_sck0_rise;
          w_shift_dev = ~cs1_n & w_sck1_rise;
        end else if (w_job_valid) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (host_hold) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end else begin
          w_push = shapool_success & w_not_full;
          // A poll via cs1_n still lets a same-cycle hit land in the FIFO.
          if (!cs1_n || (w_push && w_last_slot)) begin
            w_state_nxt = S_DONE;
            w_ro_reload = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (host_hold) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end else if (cs1_n) begin
          w_ro_reload = 1'b1;
        end else begin
          w_ro_shift = w_sck1_rise;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Frame-start image: occupancy after any same-cycle push, then the head.
  assign w_count_nxt  = r_count + COUNT_WIDTH'(w_push);
  assign w_head       = (r_count != '0) ? r_mem[r_rd_ptr]
                      : (w_push ? shapool_result : '0);
  assign w_ro_shifted = {r_readout[RO_W-2:0], w_sdi1};
  assign w_pop        = w_ro_shift && (r_phase == F_ENTRY)
                        && (r_frame_cnt == FC_W'(RESULT_DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_LOAD;
      r_core_reset_n  <= 1'b0;
      r_job_config    <= '0;
      r_device_config <= '0;
      r_job_bits      <= '0;
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_readout       <= '0;
      r_phase         <= F_HDR;
      r_frame_cnt     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      // Core runs only from the cycle after EXEC is entered, and drops in
      // the same cycle EXEC is left.
      r_core_reset_n <= (r_state == S_EXEC) && (w_state_nxt == S_EXEC);

      if (w_shift_job) r_job_config <= {r_job_config[JOB_CONFIG_WIDTH-2:0], w_sdi0};
      if (w_shift_dev) r_device_config <= {r_device_config[DEVICE_CONFIG_WIDTH-2:0], w_sdi1};

      if (w_clear)                       r_job_bits <= '0;
      else if (w_shift_job && !w_job_valid) r_job_bits <= r_job_bits + JBW'(1);

      // Push happens only in EXEC and pop only in DONE, so never together.
      if (w_clear) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= w_count_nxt - COUNT_WIDTH'(w_pop);
      end

      if (w_clear) begin
        r_readout   <= '0;
        r_phase     <= F_HDR;
        r_frame_cnt <= '0;
      end else if (w_ro_reload) begin
        r_readout   <= {w_count_nxt, w_head};
        r_phase     <= F_HDR;
        r_frame_cnt <= '0;
      end else if (w_ro_shift) begin
        r_readout <= w_ro_shifted;
        case (r_phase)
          F_HDR: begin
            if (r_frame_cnt == FC_W'(COUNT_WIDTH - 1)) begin
              // The head entry already sits in the top bits after the header.
              r_frame_cnt <= '0;
              r_phase     <= (r_count != '0) ? F_ENTRY : F_PASS;
            end else begin
              r_frame_cnt <= r_frame_cnt + FC_W'(1);
            end
          end
          F_ENTRY: begin
            if (w_pop) begin
              r_frame_cnt <= '0;
              if (r_count != COUNT_WIDTH'(1)) begin
                r_readout <= {r_mem[ptr_inc(r_rd_ptr)], w_ro_shifted[COUNT_WIDTH-1:0]};
              end else begin
                r_phase <= F_PASS;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + FC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is not reset; pointers and count define validity, so stale words are never read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= shapool_result;
  end

  assign device_config = r_device_config;
  assign job_config    = r_job_config;
  assign job_valid     = w_job_valid;
  assign core_reset_n  = r_core_reset_n;
  assign ready         = (r_state == S_DONE);
  assign result_count  = r_count;
  assign sdo1          = (r_state == S_DONE) ? r_readout[RO_W-1]
                                             : r_device_config[DEVICE_CONFIG_WIDTH-1];

endmodule

// File: tb/tb_external_io_fifo.sv
// ---------------------------------------------------------------------------
// tb_external_io_fifo
//   Randomised bench for external_io_fifo. The stimulus thread keeps a
//   reference model (shifted config images, a queue of buffered results)
//   and pushes each expected frame field into a scoreboard queue as it reads
//   it; a monitor collects sdo1 bits on SPI1 rising edges during readout and
//   compares whole fields against that queue.
// ---------------------------------------------------------------------------
module tb_external_io_fifo;

  localparam int DCW   = 8;
  localparam int JCW   = 352;
  localparam int RDW   = 40;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int SYNC  = 2;

  logic           clk, reset, host_hold;
  logic           sck0, sdi0, cs0_n, sck1, sdi1, sdo1, cs1_n;
  logic [DCW-1:0] device_config;
  logic [JCW-1:0] job_config;
  logic           job_valid, core_reset_n, shapool_success, ready;
  logic [RDW-1:0] shapool_result;
  logic [CW-1:0]  result_count;

  external_io_fifo #(
    .DEVICE_CONFIG_WIDTH(DCW), .JOB_CONFIG_WIDTH(JCW), .RESULT_DATA_WIDTH(RDW),
    .RESULT_DEPTH(DEPTH), .COUNT_WIDTH(CW), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .host_hold(host_hold),
    .sck0(sck0), .sdi0(sdi0), .cs0_n(cs0_n),
    .sck1(sck1), .sdi1(sdi1), .sdo1(sdo1), .cs1_n(cs1_n),
    .device_config(device_config), .job_config(job_config), .job_valid(job_valid),
    .core_reset_n(core_reset_n), .shapool_success(shapool_success),
    .shapool_result(shapool_result), .ready(ready), .result_count(result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          width;
    logic [63:0] value;
  } item_t;

  int             n_checks = 0;
  int             n_fail   = 0;
  item_t          exp_q[$];
  logic [RDW-1:0] model_fifo[$];
  logic [JCW-1:0] exp_job = '0;
  logic [DCW-1:0] exp_dev = '0;
  int             job_bits = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi0_bit(input logic b);
    sdi0 = b; sck0 = 1'b0; tick(SYNC + 1);
    sck0 = 1'b1; tick(SYNC + 1);
    sck0 = 1'b0;
  endtask

  task automatic spi1_bit(input logic b);
    sdi1 = b; sck1 = 1'b0; tick(SYNC + 1);
    sck1 = 1'b1; tick(SYNC + 1);
    sck1 = 1'b0;
  endtask

  task automatic shift_job(input int n);
    logic b;
    host_hold = 1'b1; cs0_n = 1'b0; tick(1);
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(1, 0));
      spi0_bit(b);
      exp_job = {exp_job[JCW-2:0], b};
      if (job_bits < JCW) job_bits++;
    end
    cs0_n = 1'b1; tick(1);
  endtask

  task automatic shift_dev(input int n);
    logic b;
    host_hold = 1'b1; cs1_n = 1'b0; tick(1);
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(1, 0));
      spi1_bit(b);
      exp_dev = {exp_dev[DCW-2:0], b};
    end
    cs1_n = 1'b1; tick(1);
  endtask

  // Host returns to LOAD: the block drops its FIFO and job bit count.
  task automatic enter_load();
    host_hold = 1'b1; tick(1);
    job_bits = 0;
    model_fifo.delete();
  endtask

  task automatic run_job();
    shift_job(JCW);
    check("job_valid_before_run", 512'(job_valid), 512'(job_bits == JCW));
    host_hold = 1'b0; tick(2);
    check("core_run", 512'(core_reset_n), 512'(1));
  endtask

  task automatic pulse_success();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    shapool_result = r[RDW-1:0]; shapool_success = 1'b1;
    if (model_fifo.size() < DEPTH) model_fifo.push_back(r[RDW-1:0]);
    tick(1);
    shapool_success = 1'b0;
  endtask

  task automatic read_header();
    item_t it;
    it.width = CW; it.value = 64'(model_fifo.size());
    exp_q.push_back(it);
    repeat (CW) spi1_bit(1'($urandom_range(1, 0)));
  endtask

  task automatic read_entry();
    item_t it;
    it.width = RDW; it.value = 64'(model_fifo.pop_front());
    exp_q.push_back(it);
    repeat (RDW) spi1_bit(1'($urandom_range(1, 0)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_config"},    512'(job_config),    512'(0));
    check({tag, "_device_config"}, 512'(device_config), 512'(0));
    check({tag, "_job_valid"},     512'(job_valid),     512'(0));
    check({tag, "_core_reset_n"},  512'(core_reset_n),  512'(0));
    check({tag, "_ready"},         512'(ready),         512'(0));
    check({tag, "_result_count"},  512'(result_count),  512'(0));
    check({tag, "_sdo1"},          512'(sdo1),          512'(0));
  endtask

  // Readout monitor: sdo1 is stable when the host raises sck1.
  initial begin
    logic [63:0] acc;
    int          nb;
    item_t       it;
    acc = '0; nb = 0;
    forever begin
      @(posedge sck1);
      if (!cs1_n && ready) begin
        acc = {acc[62:0], sdo1};
        nb++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL stream_extra_bit: got %0b expected no bit", sdo1);
          nb = 0; acc = '0;
        end else if (nb == exp_q[0].width) begin
          it = exp_q.pop_front();
          check((it.width == CW) ? "frame_hdr" : "frame_entry", 512'(acc), 512'(it.value));
          nb = 0; acc = '0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; host_hold = 1'b1;
    sck0 = 1'b0; sdi0 = 1'b0; cs0_n = 1'b1;
    sck1 = 1'b0; sdi1 = 1'b0; cs1_n = 1'b1;
    shapool_success = 1'b0; shapool_result = '0;
    tick(4);
    check_reset_outputs("reset");
    reset = 1'b0; tick(1);

    // One bit short of a full job: no run allowed.
    shift_job(JCW - 1);
    check("job_valid_short", 512'(job_valid), 512'(job_bits == JCW));
    host_hold = 1'b0; tick(4);
    check("short_core_reset_n", 512'(core_reset_n), 512'(0));
    check("short_ready", 512'(ready), 512'(0));

    // Complete, then overshoot: the count saturates, the image keeps shifting.
    shift_job(1);
    check("job_valid_exact", 512'(job_valid), 512'(job_bits == JCW));
    shift_job(2);
    check("job_valid_sat", 512'(job_valid), 512'(job_bits == JCW));
    check("job_config", 512'(job_config), 512'(exp_job));
    shift_dev(DCW);
    check("device_config", 512'(device_config), 512'(exp_dev));
    check("sdo1_load", 512'(sdo1), 512'(exp_dev[DCW-1]));

    host_hold = 1'b0; tick(1);
    check("core_reset_n_1cyc", 512'(core_reset_n), 512'(0));
    tick(1);
    check("core_reset_n_2cyc", 512'(core_reset_n), 512'(1));

    // Fill to depth: DONE on the last push.
    for (int k = 0; k < DEPTH; k++) begin
      pulse_success();
      check("fill_count", 512'(result_count), 512'(model_fifo.size()));
      check("fill_ready", 512'(ready), 512'(model_fifo.size() == DEPTH));
    end
    tick(1);
    check("done_core_reset_n", 512'(core_reset_n), 512'(0));
    cs1_n = 1'b0; tick(1);
    read_header();
    for (int k = 0; k < DEPTH; k++) read_entry();
    cs1_n = 1'b1; tick(2);
    check("drained_count", 512'(result_count), 512'(model_fifo.size()));
    // Empty frame: header 0 only.
    cs1_n = 1'b0; tick(1);
    read_header();
    cs1_n = 1'b1; tick(2);
    shapool_result = 40'h5a5a5a5a5a; shapool_success = 1'b1; tick(1);
    shapool_success = 1'b0;
    check("done_ignores_success", 512'(result_count), 512'(0));
    enter_load();
    check("hold_ready", 512'(ready), 512'(0));

    // Poll with two results; partial readout then re-frame.
    run_job();
    pulse_success(); pulse_success();
    cs1_n = 1'b0; tick(1);
    check("poll_ready", 512'(ready), 512'(1));
    check("poll_count", 512'(result_count), 512'(model_fifo.size()));
    read_header(); read_entry();
    cs1_n = 1'b1; tick(2);
    check("reframe_count", 512'(result_count), 512'(model_fifo.size()));
    cs1_n = 1'b0; tick(1);
    read_header(); read_entry();
    cs1_n = 1'b1; tick(2);
    enter_load();

    // Hit and poll in the same cycle.
    run_job();
    cs1_n = 1'b0;
    pulse_success();
    check("same_cycle_ready", 512'(ready), 512'(1));
    check("same_cycle_count", 512'(result_count), 512'(model_fifo.size()));
    read_header(); read_entry();
    cs1_n = 1'b1; tick(2);
    enter_load();

    // host_hold mid-readout dominates cs1_n.
    run_job();
    pulse_success(); pulse_success(); pulse_success();
    cs1_n = 1'b0; tick(1);
    read_header();
    enter_load();
    check("abort_ready", 512'(ready), 512'(0));
    check("abort_count", 512'(result_count), 512'(0));
    check("abort_core_reset_n", 512'(core_reset_n), 512'(0));
    cs1_n = 1'b1; tick(1);

    // Reset in the middle of EXEC.
    run_job();
    pulse_success();
    reset = 1'b1; tick(1);
    check_reset_outputs("exec_reset");
    reset = 1'b0; tick(2);

    check("stream_drained", 512'(exp_q.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
